// File: rtl/jt51_pkg.sv
// Register map constants and address decode shared by the jt51 timer front end.
package jt51_pkg;

   localparam logic [7:0] TMR_A_HI = 8'h10;
   localparam logic [7:0] TMR_A_LO = 8'h11;
   localparam logic [7:0] TMR_B    = 8'h12;
   localparam logic [7:0] TMR_CTL  = 8'h14;

   localparam int CTL_LDA  = 0;
   localparam int CTL_LDB  = 1;
   localparam int CTL_IRQA = 2;
   localparam int CTL_IRQB = 3;
   localparam int CTL_CLRA = 4;
   localparam int CTL_CLRB = 5;
   localparam int CTL_CSM  = 7;

   typedef enum logic [2:0] {
      SEL_A_HI  = 3'd0,
      SEL_A_LO  = 3'd1,
      SEL_B     = 3'd2,
      SEL_CTL   = 3'd3,
      SEL_OTHER = 3'd4
   } reg_sel_e;

   function automatic reg_sel_e reg_decode(input logic [7:0] addr);
      case (addr)
         TMR_A_HI: reg_decode = SEL_A_HI;
         TMR_A_LO: reg_decode = SEL_A_LO;
         TMR_B:    reg_decode = SEL_B;
         TMR_CTL:  reg_decode = SEL_CTL;
         default:  reg_decode = SEL_OTHER;
      endcase
   endfunction

endpackage

// File: rtl/jt51_busy_cnt.sv
// Write-busy countdown: reloads on every accepted data write, counts down on cen.
module jt51_busy_cnt #(
   parameter int BUSY_CYC = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic cen,
   output logic busy
);

   logic [7:0] cnt_r;
   logic [7:0] cnt_nxt_s;

   // Next count; a reload in the same cycle as the final decrement wins.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (load) begin
         cnt_nxt_s = 8'(BUSY_CYC);
      end else if (cen && (cnt_r != 8'd0)) begin
         cnt_nxt_s = cnt_r - 8'd1;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Counter and registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
         busy  <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         busy  <= (cnt_nxt_s != 8'd0);
      end
   end

endmodule

// File: rtl/jt51_timer_ctrl.sv
// CPU register front end for jt51_timers: timer registers, control pulses,
// status byte, CSM key-on and pass-through of all other register writes.
module jt51_timer_ctrl
   import jt51_pkg::*;
#(
   parameter int BUSY_CYC = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   input  logic       zero,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       flag_A,
   input  logic       flag_B,
   input  logic       overflow_A,
   output logic [9:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       clr_flag_A,
   output logic       clr_flag_B,
   output logic       enable_irq_A,
   output logic       enable_irq_B,
   output logic       csm_kon,
   output logic       busy,
   output logic       reg_wr,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_din
);

   logic       wst_s;
   logic       wst_r;
   logic       acc_addr_s;
   logic       acc_data_s;
   logic       csm_r;
   logic [7:0] addr_r;
   reg_sel_e   sel_s;

   // Only the rising edge of the strobe is a write, so a held strobe counts once.
   assign wst_s      = ~cs_n & ~wr_n;
   assign acc_addr_s = wst_s & ~wst_r & ~a0;
   assign acc_data_s = wst_s & ~wst_r & a0;
   assign sel_s      = reg_decode(addr_r);

   jt51_busy_cnt #(
      .BUSY_CYC (BUSY_CYC)
   ) u_busy (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (acc_data_s),
      .cen   (cen),
      .busy  (busy)
   );

   // Register file, one-clock pulses, status byte and CSM key-on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wst_r        <= 1'b0;
         addr_r       <= 8'h00;
         csm_r        <= 1'b0;
         dout         <= 8'h00;
         value_A      <= 10'd0;
         value_B      <= 8'h00;
         load_A       <= 1'b0;
         load_B       <= 1'b0;
         clr_flag_A   <= 1'b0;
         clr_flag_B   <= 1'b0;
         enable_irq_A <= 1'b0;
         enable_irq_B <= 1'b0;
         csm_kon      <= 1'b0;
         reg_wr       <= 1'b0;
         reg_addr     <= 8'h00;
         reg_din      <= 8'h00;
      end else begin
         wst_r      <= wst_s;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         reg_wr     <= 1'b0;
         dout       <= {busy, 5'b00000, flag_B, flag_A};
         csm_kon    <= csm_r & cen & zero & overflow_A;
         if (acc_addr_s) begin
            addr_r <= din;
         end else if (acc_data_s) begin
            case (sel_s)
               SEL_A_HI: value_A[9:2] <= din;
               SEL_A_LO: value_A[1:0] <= din[1:0];
               SEL_B:    value_B      <= din;
               SEL_CTL: begin
                  csm_r        <= din[CTL_CSM];
                  clr_flag_B   <= din[CTL_CLRB];
                  clr_flag_A   <= din[CTL_CLRA];
                  enable_irq_B <= din[CTL_IRQB];
                  enable_irq_A <= din[CTL_IRQA];
                  load_B       <= din[CTL_LDB];
                  load_A       <= din[CTL_LDA];
               end
               default: begin
                  reg_wr   <= 1'b1;
                  reg_addr <= addr_r;
                  reg_din  <= din;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// Bench for jt51_timer_ctrl: vector table, directed corner sequences and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_jt51_timer_ctrl;

   localparam int BUSY_CYC = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cen = 1'b0;
   logic       zero = 1'b0;
   logic       cs_n = 1'b1;
   logic       wr_n = 1'b1;
   logic       a0 = 1'b0;
   logic [7:0] din = 8'h00;
   logic       flag_A = 1'b0;
   logic       flag_B = 1'b0;
   logic       overflow_A = 1'b0;

   logic [7:0] dout, value_B, reg_addr, reg_din;
   logic [9:0] value_A;
   logic       load_A, load_B, clr_flag_A, clr_flag_B;
   logic       enable_irq_A, enable_irq_B, csm_kon, busy, reg_wr;

   jt51_timer_ctrl #(.BUSY_CYC(BUSY_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .cs_n(cs_n), .wr_n(wr_n),
      .a0(a0), .din(din), .dout(dout), .flag_A(flag_A), .flag_B(flag_B),
      .overflow_A(overflow_A), .value_A(value_A), .value_B(value_B),
      .load_A(load_A), .load_B(load_B), .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
      .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B), .csm_kon(csm_kon),
      .busy(busy), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_din(reg_din)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: busy is a plain countdown of remaining cen ticks.
   bit         m_prev_wst, m_csm;
   logic [7:0] m_addr;
   int         m_cnt;
   logic [7:0] e_dout, e_vb, e_raddr, e_rdin;
   logic [9:0] e_va;
   logic       e_lda, e_ldb, e_clra, e_clrb, e_irqa, e_irqb, e_kon, e_busy, e_rw;

   logic [50:0] act_v, exp_v;
   assign act_v = {dout, value_A, value_B, load_A, load_B, clr_flag_A, clr_flag_B,
                   enable_irq_A, enable_irq_B, csm_kon, busy, reg_wr, reg_addr, reg_din};
   assign exp_v = {e_dout, e_va, e_vb, e_lda, e_ldb, e_clra, e_clrb,
                   e_irqa, e_irqb, e_kon, e_busy, e_rw, e_raddr, e_rdin};

   task automatic model_reset();
      m_prev_wst = 1'b0; m_csm = 1'b0; m_addr = 8'h00; m_cnt = 0;
      e_dout = 8'h00; e_vb = 8'h00; e_raddr = 8'h00; e_rdin = 8'h00; e_va = 10'd0;
      e_lda = 1'b0; e_ldb = 1'b0; e_clra = 1'b0; e_clrb = 1'b0; e_irqa = 1'b0;
      e_irqb = 1'b0; e_kon = 1'b0; e_busy = 1'b0; e_rw = 1'b0;
   endtask

   task automatic model_edge();
      bit wst, acc;
      wst = !cs_n && !wr_n;
      acc = wst && !m_prev_wst;
      m_prev_wst = wst;
      e_dout = {e_busy, 5'b00000, flag_B, flag_A};
      e_kon  = m_csm && cen && zero && overflow_A;
      e_clra = 1'b0; e_clrb = 1'b0; e_rw = 1'b0;
      if (cen && m_cnt > 0) m_cnt = m_cnt - 1;
      if (acc && !a0) m_addr = din;
      if (acc && a0) begin
         m_cnt = BUSY_CYC;
         if (m_addr == 8'h10) e_va = {din, e_va[1:0]};
         else if (m_addr == 8'h11) e_va = {e_va[9:2], din[1:0]};
         else if (m_addr == 8'h12) e_vb = din;
         else if (m_addr == 8'h14) begin
            m_csm = din[7]; e_clrb = din[5]; e_clra = din[4];
            e_irqb = din[3]; e_irqa = din[2]; e_ldb = din[1]; e_lda = din[0];
         end else begin
            e_rw = 1'b1; e_raddr = m_addr; e_rdin = din;
         end
      end
      e_busy = (m_cnt > 0);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      check("model", 64'(act_v), 64'(exp_v));
   endtask

   task automatic wr_start(input logic a, input logic [7:0] d);
      cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
      cyc();
      cs_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic busy_len(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         cyc();
      end
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [9:0] va;
      logic [7:0] vb;
      logic [3:0] ctl;
      logic [1:0] clr;
      logic       rw;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] addrs[6];

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      int pulses;

      // {irqB,irqA,ldB,ldA} in ctl, {clrB,clrA} in clr
      vecs[0] = '{8'h10, 8'hAB, 10'h2AC, 8'h00, 4'h0, 2'b00, 1'b0};
      vecs[1] = '{8'h11, 8'h03, 10'h2AF, 8'h00, 4'h0, 2'b00, 1'b0};
      vecs[2] = '{8'h12, 8'h5A, 10'h2AF, 8'h5A, 4'h0, 2'b00, 1'b0};
      vecs[3] = '{8'h14, 8'h3F, 10'h2AF, 8'h5A, 4'hF, 2'b11, 1'b0};
      vecs[4] = '{8'h28, 8'h5C, 10'h2AF, 8'h5A, 4'hF, 2'b00, 1'b1};
      vecs[5] = '{8'h14, 8'h05, 10'h2AF, 8'h5A, 4'h5, 2'b00, 1'b0};
      vecs[6] = '{8'h14, 8'h10, 10'h2AF, 8'h5A, 4'h0, 2'b01, 1'b0};
      addrs = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h28, 8'h30};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", 64'(act_v), 64'd0);
      model_reset();
      rst_n = 1'b1;
      cen = 1'b1;
      cyc();
      check("post_reset_dout", dout, 8'h00);

      for (int i = 0; i < 7; i++) begin
         wr_start(1'b0, vecs[i].addr);
         cyc();
         wr_start(1'b1, vecs[i].data);
         check("vec_value_A", value_A, vecs[i].va);
         check("vec_value_B", value_B, vecs[i].vb);
         check("vec_ctl", {enable_irq_B, enable_irq_A, load_B, load_A}, vecs[i].ctl);
         check("vec_clr", {clr_flag_B, clr_flag_A}, vecs[i].clr);
         check("vec_reg_wr", reg_wr, vecs[i].rw);
         check("vec_busy", busy, 1'b1);
         if (vecs[i].rw) begin
            check("vec_reg_addr", reg_addr, vecs[i].addr);
            check("vec_reg_din", reg_din, vecs[i].data);
         end
         cyc();
         check("vec_pulse_end", {clr_flag_B, clr_flag_A, reg_wr}, 3'b000);
      end

      // Timer A value split over two registers, busy length after each.
      wr_start(1'b0, 8'h10); cyc();
      wr_start(1'b1, 8'hAB);
      busy_len(n);
      check("busy_len_hi", n, 32);
      wr_start(1'b0, 8'h11); cyc();
      wr_start(1'b1, 8'h03);
      check("value_A_2AF", value_A, 10'h2AF);
      busy_len(n);
      check("busy_len_lo", n, 32);

      // Held strobe on the control register gives a single clear pulse.
      wr_start(1'b0, 8'h14); cyc();
      cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h3F;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         pulses += int'(clr_flag_A) + int'(clr_flag_B);
      end
      cs_n = 1'b1; wr_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         pulses += int'(clr_flag_A) + int'(clr_flag_B);
      end
      check("held_strobe_pulses", pulses, 2);
      check("ctl_3F", {enable_irq_B, enable_irq_A, load_B, load_A}, 4'hF);

      // CSM key-on follows timer A overflow only while csm is set.
      wr_start(1'b0, 8'h10); cyc(); wr_start(1'b1, 8'hFF); cyc();
      wr_start(1'b0, 8'h11); cyc(); wr_start(1'b1, 8'h03); cyc();
      check("value_A_3FF", value_A, 10'h3FF);
      wr_start(1'b0, 8'h14); cyc(); wr_start(1'b1, 8'h81); cyc();
      zero = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         overflow_A = (i % 2 == 0);
         cyc();
         pulses += int'(csm_kon);
      end
      overflow_A = 1'b0; cyc(); pulses += int'(csm_kon);
      check("csm_pulses_on", pulses, 3);
      wr_start(1'b0, 8'h14); cyc(); wr_start(1'b1, 8'h01); cyc();
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         overflow_A = (i % 2 == 0);
         cyc();
         pulses += int'(csm_kon);
      end
      overflow_A = 1'b0; cyc(); pulses += int'(csm_kon);
      check("csm_pulses_off", pulses, 0);
      zero = 1'b0;

      // Restart busy when three ticks remain; status shows flag_A.
      wr_start(1'b0, 8'h28); cyc();
      wr_start(1'b1, 8'h11);
      repeat (29) cyc();
      check("busy_before_restart", busy, 1'b1);
      flag_A = 1'b1;
      wr_start(1'b1, 8'h22);
      check("status_81", dout, 8'h81);
      busy_len(n);
      check("busy_len_restart", n, 32);
      flag_A = 1'b0;

      // Asynchronous reset in the middle of a busy period.
      wr_start(1'b1, 8'h33);
      repeat (3) cyc();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 64'(act_v), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      cyc();
      check("reset_busy", busy, 1'b0);
      check("reset_dout", dout, 8'h00);

      for (int i = 0; i < 1500; i++) begin
         cen        = ($urandom_range(0, 3) != 0);
         zero       = 1'($urandom);
         overflow_A = ($urandom_range(0, 3) == 0);
         flag_A     = 1'($urandom);
         flag_B     = 1'($urandom);
         cs_n       = ($urandom_range(0, 2) == 0);
         wr_n       = ($urandom_range(0, 2) == 0);
         a0         = 1'($urandom);
         if (a0) din = 8'($urandom);
         else din = addrs[$urandom_range(0, 5)];
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
